// File: rtl/dac_stream_pkg.sv
// dac_stream_pkg: shared types and default constants for dac_stream_serializer.
//   ser_state_e      - serializer FSM states
//   FIFO_AW          - sample FIFO address width at the default depth
//   DEF_*            - default parameter values used by the top
package dac_stream_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_DIV_WIDTH   = 16;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;
    localparam int unsigned DEF_SPI_CLK_DIV = 2;
    localparam int unsigned FIFO_AW         = $clog2(DEF_FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StGap
    } ser_state_e;

endpackage

// File: rtl/dac_stream_serializer_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with flop storage.
//   clk_i, rst_ni     - clock, asynchronous active-low reset (flushes contents)
//   push_i, wdata_i   - write request and data; ignored when full unless popping
//   pop_i             - read request; ignored when empty
//   rdata_o           - head entry, valid whenever empty_o is low
//   full_o, empty_o   - occupancy flags
//   count_o           - number of stored entries
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int unsigned Aw = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [Aw-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [Aw:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (Aw+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + Aw'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + Aw'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (Aw+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (Aw+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dac_stream_serializer.sv
// dac_stream_serializer: paces generator requests, buffers returned samples and
// shifts each one to an 8-bit SPI DAC (mode 0, MSB first).
//   clk_i, rst_i          - clock, asynchronous active-low reset
//   enable_i, rate_div_i  - run the request tick; period is rate_div_i+1 cycles
//   data_i, data_valid_strobe_i - returned sample and its one-cycle strobe
//   clear_flags_i         - clears sticky overrun_o
//   next_data_strobe_o    - one-cycle request to the generators
//   sclk_o, cs_n_o, mosi_o - SPI bus
//   overrun_o             - sticky: tick skipped or sample dropped
//   busy_o                - frame in progress (shifting or inter-frame gap)
// Build option: define OFFSET_BINARY_EN to invert each sample MSB at pop.
module dac_stream_serializer
    import dac_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned DIV_WIDTH   = DEF_DIV_WIDTH,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned SPI_CLK_DIV = DEF_SPI_CLK_DIV
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [DIV_WIDTH-1:0]  rate_div_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_strobe_i,
    input  logic                  clear_flags_i,
    output logic                  next_data_strobe_o,
    output logic                  sclk_o,
    output logic                  cs_n_o,
    output logic                  mosi_o,
    output logic                  overrun_o,
    output logic                  busy_o
);
    localparam int unsigned FifoAw = $clog2(FIFO_DEPTH);
    localparam int unsigned BitW   = $clog2(DATA_WIDTH);
    localparam int unsigned CycW   = (SPI_CLK_DIV > 1) ? $clog2(SPI_CLK_DIV) : 1;

    // Rate tick and request gating
    logic [DIV_WIDTH-1:0] rate_cnt_q, rate_cnt_d, div_q, div_d, rate_limit;
    logic                 tick, req_ok, drop;
    logic                 strobe_q, strobe_d;
    logic                 outstanding_q, outstanding_d;
    logic                 overrun_q, overrun_d;
    int unsigned          occupancy;

    // FIFO
    logic [FifoAw:0]      fifo_count;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_rdata, sample;

    // Serializer
    ser_state_e            state_q, state_d;
    logic [CycW-1:0]       cyc_q, cyc_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
    logic                  cyc_last;

    // The period is taken from rate_div_i at count 0 and held for the rest of it.
    always_comb begin
        rate_limit = (rate_cnt_q == '0) ? rate_div_i : div_q;
        rate_cnt_d = '0;
        div_d      = div_q;
        tick       = 1'b0;
        if (enable_i) begin
            if (rate_cnt_q == '0) begin
                div_d = rate_div_i;
            end
            if (rate_cnt_q == rate_limit) begin
                tick = 1'b1;
            end else begin
                rate_cnt_d = rate_cnt_q + DIV_WIDTH'(1);
            end
        end
    end

    // Only one request in flight, and only if its answer is sure to fit.
    always_comb begin
        occupancy = 32'(fifo_count) + 32'(outstanding_q);
        req_ok    = tick && !outstanding_q && (occupancy < FIFO_DEPTH);
        drop      = data_valid_strobe_i && fifo_full && !fifo_pop;
        strobe_d  = req_ok;

        outstanding_d = outstanding_q;
        if (req_ok) begin
            outstanding_d = 1'b1;
        end else if (data_valid_strobe_i) begin
            outstanding_d = 1'b0;
        end

        overrun_d = overrun_q;
        if ((tick && !req_ok) || drop) begin
            overrun_d = 1'b1;
        end else if (clear_flags_i) begin
            overrun_d = 1'b0;
        end
    end

    sync_fifo #(
        .Width (DATA_WIDTH),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_i),
        .push_i  (data_valid_strobe_i),
        .wdata_i (data_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef OFFSET_BINARY_EN
    // Two's complement to offset binary for unipolar DACs.
    assign sample = {~fifo_rdata[DATA_WIDTH-1], fifo_rdata[DATA_WIDTH-2:0]};
`else
    assign sample = fifo_rdata;
`endif

    assign cyc_last = (cyc_q == CycW'(SPI_CLK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        fifo_pop  = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shreg_d   = sample;
                    mosi_d    = sample[DATA_WIDTH-1];
                    cs_n_d    = 1'b0;
                    bit_cnt_d = BitW'(DATA_WIDTH - 1);
                    cyc_d     = '0;
                    state_d   = StShiftLo;
                end
            end
            StShiftLo: begin
                if (cyc_last) begin
                    cyc_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = StShiftHi;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StShiftHi: begin
                if (cyc_last) begin
                    cyc_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_cnt_q == '0) begin
                        cs_n_d  = 1'b1;
                        state_d = StGap;
                    end else begin
                        // Next bit goes out on the falling edge, stable for the next rise.
                        bit_cnt_d = bit_cnt_q - BitW'(1);
                        shreg_d   = shreg_q << 1;
                        mosi_d    = shreg_d[DATA_WIDTH-1];
                        state_d   = StShiftLo;
                    end
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StGap: begin
                if (cyc_last) begin
                    cyc_d   = '0;
                    state_d = StIdle;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rate_cnt_q    <= '0;
            div_q         <= '0;
            strobe_q      <= 1'b0;
            outstanding_q <= 1'b0;
            overrun_q     <= 1'b0;
            state_q       <= StIdle;
            cyc_q         <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            sclk_q        <= 1'b0;
            cs_n_q        <= 1'b1;
            mosi_q        <= 1'b0;
        end else begin
            rate_cnt_q    <= rate_cnt_d;
            div_q         <= div_d;
            strobe_q      <= strobe_d;
            outstanding_q <= outstanding_d;
            overrun_q     <= overrun_d;
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            sclk_q        <= sclk_d;
            cs_n_q        <= cs_n_d;
            mosi_q        <= mosi_d;
        end
    end

    assign next_data_strobe_o = strobe_q;
    assign overrun_o          = overrun_q;
    assign sclk_o             = sclk_q;
    assign cs_n_o             = cs_n_q;
    assign mosi_o             = mosi_q;
    assign busy_o             = (state_q != StIdle);

endmodule

// File: doc/dac_stream_serializer.md
Name: dac_stream_serializer

Overview:
Downstream stage of the waveform generator top. Paces sample requests to the generators via a programmable rate tick (next_data_strobe_o). Buffers the returned 8-bit samples in a small FIFO. Serializes each sample to an external 8-bit SPI DAC (mode 0, MSB first), decoupling generator latency from DAC frame timing.

Parameters:
DATA_WIDTH, 8, sample width and bits per SPI frame
DIV_WIDTH, 16, width of the sample-rate divider
FIFO_DEPTH, 4, sample buffer entries (power of 2, at least 2)
SPI_CLK_DIV, 2, clk cycles per SCLK half-period (at least 1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-low
enable_i  in  1  run rate tick; low = no new requests
rate_div_i  in  DIV_WIDTH  tick period minus 1, in clk cycles
data_i  in  DATA_WIDTH  sample from selected generator
data_valid_strobe_i  in  1  one-cycle strobe, data_i valid
clear_flags_i  in  1  clears sticky overrun_o
next_data_strobe_o  out  1  one-cycle request to generators
sclk_o  out  1  SPI clock, idle low
cs_n_o  out  1  SPI chip select, active low
mosi_o  out  1  SPI data
overrun_o  out  1  sticky: a tick was skipped or a sample dropped
busy_o  out  1  high while a frame is in progress (cs_n_o low or gap)

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous, active-low.
- Reset values: next_data_strobe_o=0, sclk_o=0, cs_n_o=1, mosi_o=0, overrun_o=0, busy_o=0. Rate counter=0, FIFO empty, outstanding=0, FSM=IDLE.
- Rate counter:
  - Counts 0..rate_div_i while enable_i=1, then wraps to 0. Tick period is rate_div_i+1 cycles; rate_div_i=0 ticks every cycle.
  - rate_div_i is sampled at wrap. enable_i=0 holds the counter at 0.
- Request gating, on a tick:
  - If outstanding=0 and fifo_count+outstanding < FIFO_DEPTH: next_data_strobe_o=1 for exactly one cycle (registered, the cycle after the terminal count) and outstanding<=1.
  - Otherwise no strobe, and overrun_o<=1.
- Sample capture:
  - data_valid_strobe_i pushes data_i and clears outstanding.
  - Push while the FIFO is full with no same-cycle pop: sample dropped, overrun_o<=1.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Push on a full FIFO with a same-cycle pop is accepted.
- overrun_o: clear_flags_i clears it; a same-cycle set wins over the clear.
- Serializer FSM (D = SPI_CLK_DIV):
  - IDLE: if the FIFO is not empty, pop; shreg<=sample; cs_n_o<=0; mosi_o<=sample MSB; bit_cnt<=DATA_WIDTH-1; go to SHIFT_LO.
  - SHIFT_LO: D cycles with sclk_o=0, then go to SHIFT_HI.
  - SHIFT_HI: D cycles with sclk_o=1. At the end, if bit_cnt=0: cs_n_o<=1, sclk_o<=0, go to GAP. Otherwise bit_cnt--, shift the next bit onto mosi_o, go to SHIFT_LO.
  - mosi_o changes only when sclk_o goes low, so it is stable across each rising edge.
  - GAP: D cycles, cs_n_o=1, then go to IDLE.
  - Frame spacing: 1+(2*DATA_WIDTH+1)*D cycles, which is 35 at the defaults.
- enable_i low mid-frame: the current frame completes; remaining FIFO entries still drain; an outstanding response is still accepted.
- Reset mid-frame: outputs immediately take their reset values (cs_n_o=1) and the FIFO is flushed.
- busy_o=1 in SHIFT_LO, SHIFT_HI and GAP.

Optional Feature:
OFFSET_BINARY_EN:
- Defined: the MSB of each sample is inverted at pop, converting two's complement to offset binary for unipolar DACs.
- Undefined: samples are shifted out unchanged.

Decomposition:
- Package dac_stream_pkg:
  - serializer state enum (IDLE, SHIFT_LO, SHIFT_HI, GAP)
  - FIFO_AW = log2(FIFO_DEPTH)
  - default DATA_WIDTH, DIV_WIDTH and SPI_CLK_DIV constants
- One sub-module: sync_fifo.
  - Parameterized width/depth, with push, pop, full, empty and count.
  - Async active-low reset, registered read data.
  - Show-ahead output, so the pop-cycle data is valid.

Test Plan:
- Reset, then enable_i=1, rate_div_i=49, upstream answers 3 cycles after each strobe -> next_data_strobe_o pulses exactly every 50 cycles, one cycle wide; overrun_o stays 0.
- Push 8'hA5, D=2 -> cs_n_o low for 32 cycles; mosi_o sampled on the 8 sclk_o rising edges = 1,0,1,0,0,1,0,1; next frame cs_n_o falls no earlier than 35 cycles after the previous one.
- rate_div_i=3, responses 1 cycle after strobe -> FIFO fills to 4 within about 20 cycles; strobes then suppressed and overrun_o=1; clear_flags_i pulse -> 0 until the next skipped tick.
- Inject data_valid_strobe_i with FIFO full and no pop -> sample dropped, count stays 4, overrun_o=1. Push on the same cycle IDLE pops -> accepted, count stays 4.
- Assert rst_i=0 during SHIFT_HI of bit 4 -> same cycle: cs_n_o=1, sclk_o=0, busy_o=0; after release no frame starts until a new sample arrives.
- With OFFSET_BINARY_EN defined: push 8'h80 -> serial word 8'h00; push 8'h7F -> 8'hFF. Without it, words are unchanged.
